// File: rtl/piece_drop.sv
// rtl/piece_drop.sv - active-piece engine: spawn, gravity, lateral moves, landing and merge
// Hands the merged board to the line-clear block and adopts the board it returns.
module piece_drop #(
  parameter int ROWS      = 8,
  parameter int SPAWN_ROW = 0
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        curr_piece,
  input  logic              drop_tick,
  input  logic              move_left,
  input  logic              move_right,
  input  logic [4*ROWS-1:0] board_in,
  input  logic              clear_done,
  output logic [4*ROWS-1:0] board_out,
  output logic [4*ROWS-1:0] piece_mask,
  output logic              clear_req,
  output logic              landed,
  output logic              busy,
  output logic              game_over
);

  localparam int W = 4 * ROWS;
  localparam logic [W-1:0] COL0 = {ROWS{4'b0001}};
  localparam logic [W-1:0] COL3 = {ROWS{4'b1000}};

  typedef enum logic [1:0] {IDLE, FALL, WAIT_CLR, OVER} state_t;

  state_t state, state_next;

  logic [W-1:0] board_next, mask_next;
  logic         landed_next, clear_next, over_next;

  logic [7:0]   spawn_base;
  logic [W-1:0] spawn_mask;
  logic         spawn_hit;
  logic [W-1:0] down_mask, left_mask, right_mask, merged;
  logic         drop_blocked, left_ok, right_ok, merged_full;

  function automatic logic has_full_row(input logic [W-1:0] b);
    logic full;
    full = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (b[4*r +: 4] == 4'hF) full = 1'b1;
    end
    return full;
  endfunction

  // Spawn patterns are defined for the top two rows, then moved down to SPAWN_ROW.
  always_comb begin
    case (curr_piece)
      2'b00:   spawn_base = 8'h02;
      2'b01:   spawn_base = 8'h06;
      2'b10:   spawn_base = 8'h66;
      default: spawn_base = 8'h62;
    endcase
    spawn_mask = {{(W-8){1'b0}}, spawn_base} << (4 * SPAWN_ROW);
    spawn_hit  = |(spawn_mask & board_out);
  end

  // Column guards stop a lateral shift from wrapping into the neighbouring row.
  always_comb begin
    down_mask    = piece_mask << 4;
    left_mask    = piece_mask >> 1;
    right_mask   = piece_mask << 1;
    merged       = board_out | piece_mask;
    drop_blocked = (|piece_mask[W-1:W-4]) || (|(down_mask & board_out));
    left_ok      = ~|(piece_mask & COL0) && ~|(left_mask & board_out);
    right_ok     = ~|(piece_mask & COL3) && ~|(right_mask & board_out);
    merged_full  = has_full_row(merged);
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state      <= IDLE;
      board_out  <= '0;
      piece_mask <= '0;
      clear_req  <= 1'b0;
      landed     <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_next;
      board_out  <= board_next;
      piece_mask <= mask_next;
      clear_req  <= clear_next;
      landed     <= landed_next;
      game_over  <= over_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = spawn_hit ? OVER : FALL;
      end
      FALL: begin
        if (drop_tick && drop_blocked) state_next = merged_full ? WAIT_CLR : IDLE;
      end
      WAIT_CLR: begin
        if (clear_done) state_next = IDLE;
      end
      default: state_next = OVER;
    endcase
  end

  // A drop_tick always wins the cycle; a move on the same cycle is dropped.
  always_comb begin
    board_next  = board_out;
    mask_next   = piece_mask;
    clear_next  = clear_req;
    landed_next = 1'b0;
    over_next   = game_over;
    case (state)
      IDLE: begin
        if (start) begin
          if (spawn_hit) over_next = 1'b1;
          else           mask_next = spawn_mask;
        end
      end
      FALL: begin
        if (drop_tick) begin
          if (drop_blocked) begin
            board_next  = merged;
            mask_next   = '0;
            landed_next = 1'b1;
            clear_next  = merged_full;
          end else begin
            mask_next = down_mask;
          end
        end else if (move_left && !move_right) begin
          if (left_ok) mask_next = left_mask;
        end else if (move_right && !move_left) begin
          if (right_ok) mask_next = right_mask;
        end
      end
      WAIT_CLR: begin
        if (clear_done) begin
          board_next = board_in;
          clear_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
